// File: rtl/arithmetic_logic_unit_stage.sv
// rtl/arithmetic_logic_unit_stage.sv - execute-stage ALU with registered EX/MEM boundary
module arithmetic_logic_unit_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [3:0]            alu_control_signal,
    input  logic                  trap_on_overflow,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [REG_ADDR_W-1:0] destination_register_in,
    input  logic                  register_write_in,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero,
    output logic [REG_ADDR_W-1:0] destination_register_out,
    output logic                  register_write_out,
    output logic                  overflow_exception,
    output logic                  illegal_operation
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  add_overflow;
    logic                  sub_overflow;
    logic                  slt_bit;
    logic [DATA_WIDTH-1:0] next_result;
    logic                  next_overflow;
    logic                  next_illegal;
    logic                  trap_taken;

    assign sum  = operand_a + operand_b;
    assign diff = operand_a - operand_b;

    // Signed overflow from operand and result sign bits
    assign add_overflow = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB]  != operand_a[MSB]);
    assign sub_overflow = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);

    // Differing signs decide directly; otherwise a-b cannot overflow and its sign is exact
    assign slt_bit = (operand_a[MSB] != operand_b[MSB]) ? operand_a[MSB] : diff[MSB];

    // Operation select; unknown codes produce a zero result and flag illegal
    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        next_illegal  = 1'b0;
        case (alu_control_signal)
            OP_AND: next_result = operand_a & operand_b;
            OP_OR:  next_result = operand_a | operand_b;
            OP_ADD: begin
                next_result   = sum;
                next_overflow = add_overflow;
            end
            OP_SUB: begin
                next_result   = diff;
                next_overflow = sub_overflow;
            end
            OP_SLT: next_result = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
            OP_NOR: next_result = ~(operand_a | operand_b);
            OP_XOR: next_result = operand_a ^ operand_b;
            default: next_illegal = 1'b1;
        endcase
    end

    assign trap_taken = valid_in && next_overflow && trap_on_overflow;

    // EX/MEM register: reset > flush > stall > load; data fields only follow live instructions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_out                <= 1'b0;
            alu_result               <= '0;
            zero                     <= 1'b0;
            destination_register_out <= '0;
            register_write_out       <= 1'b0;
            overflow_exception       <= 1'b0;
            illegal_operation        <= 1'b0;
        end else if (flush) begin
            valid_out          <= 1'b0;
            register_write_out <= 1'b0;
            overflow_exception <= 1'b0;
            illegal_operation  <= 1'b0;
        end else if (stall) begin
            overflow_exception <= 1'b0;
            illegal_operation  <= 1'b0;
        end else begin
            valid_out          <= valid_in;
            register_write_out <= valid_in && register_write_in && !next_illegal && !trap_taken;
            overflow_exception <= trap_taken;
            illegal_operation  <= valid_in && next_illegal;
            if (valid_in) begin
                alu_result               <= next_result;
                zero                     <= (next_result == '0);
                destination_register_out <= destination_register_in;
            end
        end
    end

endmodule

// File: tb/tb_arithmetic_logic_unit_stage.sv
// tb/tb_arithmetic_logic_unit_stage.sv - directed self-checking bench for arithmetic_logic_unit_stage
module tb_arithmetic_logic_unit_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;

    logic          clock;
    logic          reset;
    logic          valid_in;
    logic [3:0]    alu_control_signal;
    logic          trap_on_overflow;
    logic [DW-1:0] operand_a;
    logic [DW-1:0] operand_b;
    logic [AW-1:0] destination_register_in;
    logic          register_write_in;
    logic          stall;
    logic          flush;
    logic          valid_out;
    logic [DW-1:0] alu_result;
    logic          zero;
    logic [AW-1:0] destination_register_out;
    logic          register_write_out;
    logic          overflow_exception;
    logic          illegal_operation;

    int checks;
    int errors;

    arithmetic_logic_unit_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .valid_in                 (valid_in),
        .alu_control_signal       (alu_control_signal),
        .trap_on_overflow         (trap_on_overflow),
        .operand_a                (operand_a),
        .operand_b                (operand_b),
        .destination_register_in  (destination_register_in),
        .register_write_in        (register_write_in),
        .stall                    (stall),
        .flush                    (flush),
        .valid_out                (valid_out),
        .alu_result               (alu_result),
        .zero                     (zero),
        .destination_register_out (destination_register_out),
        .register_write_out       (register_write_out),
        .overflow_exception       (overflow_exception),
        .illegal_operation        (illegal_operation)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [3:0] op, input logic trap,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] rd, input logic we);
        valid_in                = v;
        alu_control_signal      = op;
        trap_on_overflow        = trap;
        operand_a               = a;
        operand_b               = b;
        destination_register_in = rd;
        register_write_in       = we;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, OP_AND, 1'b0, '0, '0, '0, 1'b0);
        step();
        step();
        checks++;
        if ({valid_out, alu_result, zero, destination_register_out, register_write_out,
             overflow_exception, illegal_operation} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b res=%h zero=%b rd=%h we=%b ovf=%b ill=%b exp all 0",
                     valid_out, alu_result, zero, destination_register_out, register_write_out,
                     overflow_exception, illegal_operation);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({valid_out, alu_result, zero, register_write_out} !== '0) begin
            errors++;
            $display("FAIL reset_bubble_hold got valid=%b res=%h zero=%b we=%b exp all 0",
                     valid_out, alu_result, zero, register_write_out);
        end
        // load a live result, then reset asynchronously between edges
        drive(1'b1, OP_ADD, 1'b0, 32'd10, 32'd20, 5'd9, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd30 || valid_out !== 1'b1 || destination_register_out !== 5'd9) begin
            errors++;
            $display("FAIL reset_preload got res=%h valid=%b rd=%h exp 0000001e 1 09",
                     alu_result, valid_out, destination_register_out);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({valid_out, alu_result, zero, destination_register_out, register_write_out} !== '0) begin
            errors++;
            $display("FAIL reset_async got valid=%b res=%h zero=%b rd=%h we=%b exp all 0",
                     valid_out, alu_result, zero, destination_register_out, register_write_out);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, OP_ADD, 1'b1, 32'd5, 32'd7, 5'd3, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd12 || zero !== 1'b0 || valid_out !== 1'b1 ||
            register_write_out !== 1'b1 || destination_register_out !== 5'd3) begin
            errors++;
            $display("FAIL b2b_add got res=%h zero=%b valid=%b we=%b rd=%h exp 0000000c 0 1 1 03",
                     alu_result, zero, valid_out, register_write_out, destination_register_out);
        end
        drive(1'b1, OP_SUB, 1'b1, 32'd3, 32'd3, 5'd4, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || valid_out !== 1'b1 ||
            register_write_out !== 1'b1 || destination_register_out !== 5'd4) begin
            errors++;
            $display("FAIL b2b_sub got res=%h zero=%b valid=%b we=%b rd=%h exp 00000000 1 1 1 04",
                     alu_result, zero, valid_out, register_write_out, destination_register_out);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h8000_0000 || overflow_exception !== 1'b1 ||
            register_write_out !== 1'b0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_trap got res=%h ovf=%b we=%b valid=%b exp 80000000 1 0 1",
                     alu_result, overflow_exception, register_write_out, valid_out);
        end
        drive(1'b0, OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        step();
        checks++;
        if (overflow_exception !== 1'b0 || valid_out !== 1'b0 || register_write_out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pulse_end got ovf=%b valid=%b we=%b exp 0 0 0",
                     overflow_exception, valid_out, register_write_out);
        end
        drive(1'b1, OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd5, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h8000_0000 || overflow_exception !== 1'b0 || register_write_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_notrap got res=%h ovf=%b we=%b exp 80000000 0 1",
                     alu_result, overflow_exception, register_write_out);
        end
        drive(1'b1, OP_SUB, 1'b1, 32'h8000_0000, 32'd1, 5'd6, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'h7FFF_FFFF || overflow_exception !== 1'b1 || register_write_out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sub got res=%h ovf=%b we=%b exp 7fffffff 1 0",
                     alu_result, overflow_exception, register_write_out);
        end
        // same-sign add without overflow must not trap
        drive(1'b1, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'hFFFF_FFFE || overflow_exception !== 1'b0 || register_write_out !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg_add got res=%h ovf=%b we=%b exp fffffffe 0 1",
                     alu_result, overflow_exception, register_write_out);
        end
    endtask

    task automatic test_slt();
        logic [DW-1:0] a_vec [3];
        logic [DW-1:0] b_vec [3];
        logic [DW-1:0] e_vec [3];
        a_vec[0] = 32'h8000_0000; b_vec[0] = 32'd1;         e_vec[0] = 32'd1;
        a_vec[1] = 32'd1;         b_vec[1] = 32'h8000_0000; e_vec[1] = 32'd0;
        a_vec[2] = 32'h7FFF_FFFF; b_vec[2] = 32'hFFFF_FFFF; e_vec[2] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_SLT, 1'b1, a_vec[i], b_vec[i], 5'd7, 1'b1);
            step();
            checks++;
            if (alu_result !== e_vec[i] || overflow_exception !== 1'b0 ||
                register_write_out !== 1'b1 || zero !== (e_vec[i] == 0)) begin
                errors++;
                $display("FAIL slt_%0d got res=%h ovf=%b we=%b zero=%b exp %h 0 1 %b",
                         i, alu_result, overflow_exception, register_write_out, zero,
                         e_vec[i], (e_vec[i] == 0));
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0]    op_vec [4];
        logic [DW-1:0] e_vec  [4];
        op_vec[0] = OP_AND; e_vec[0] = 32'hF000_F000;
        op_vec[1] = OP_OR;  e_vec[1] = 32'hFFF0_FFF0;
        op_vec[2] = OP_XOR; e_vec[2] = 32'h0FF0_0FF0;
        op_vec[3] = OP_NOR; e_vec[3] = 32'h000F_000F;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, op_vec[i], 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 1'b1);
            step();
            checks++;
            if (alu_result !== e_vec[i] || register_write_out !== 1'b1 || zero !== 1'b0) begin
                errors++;
                $display("FAIL logic_op%b got res=%h we=%b zero=%b exp %h 1 0",
                         op_vec[i], alu_result, register_write_out, zero, e_vec[i]);
            end
        end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, OP_ADD, 1'b1, 32'd2, 32'd2, 5'd10, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd4 || valid_out !== 1'b1 || register_write_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_load got res=%h valid=%b we=%b exp 00000004 1 1",
                     alu_result, valid_out, register_write_out);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_ADD, 1'b1, 32'h7FFF_FFF0 + i, 32'h10, 5'd11 + i, 1'b1);
            step();
            checks++;
            if (alu_result !== 32'd4 || valid_out !== 1'b1 || register_write_out !== 1'b1 ||
                destination_register_out !== 5'd10 || overflow_exception !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d got res=%h valid=%b we=%b rd=%h ovf=%b exp 00000004 1 1 0a 0",
                         i, alu_result, valid_out, register_write_out, destination_register_out,
                         overflow_exception);
            end
        end
        // a trapped result under stall must not pulse twice
        stall = 1'b0;
        drive(1'b1, OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd12, 1'b1);
        step();
        stall = 1'b1;
        drive(1'b1, OP_ADD, 1'b0, 32'd1, 32'd1, 5'd13, 1'b1);
        step();
        checks++;
        if (overflow_exception !== 1'b0 || alu_result !== 32'h8000_0000 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_repeat got ovf=%b res=%h valid=%b exp 0 80000000 1",
                     overflow_exception, alu_result, valid_out);
        end
        flush = 1'b1;
        step();
        checks++;
        if (valid_out !== 1'b0 || register_write_out !== 1'b0 || overflow_exception !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush got valid=%b we=%b ovf=%b exp 0 0 0",
                     valid_out, register_write_out, overflow_exception);
        end
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b1, OP_OR, 1'b0, 32'h1, 32'h2, 5'd14, 1'b1);
        step();
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({valid_out, alu_result, register_write_out, destination_register_out} !== '0) begin
            errors++;
            $display("FAIL stall_reset got valid=%b res=%h we=%b rd=%h exp all 0",
                     valid_out, alu_result, register_write_out, destination_register_out);
        end
        step();
        reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'b1111, 1'b1, 32'd5, 32'd3, 5'd15, 1'b1);
        step();
        checks++;
        if (alu_result !== 32'd0 || zero !== 1'b1 || illegal_operation !== 1'b1 ||
            register_write_out !== 1'b0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL illegal_op got res=%h zero=%b ill=%b we=%b valid=%b exp 00000000 1 1 0 1",
                     alu_result, zero, illegal_operation, register_write_out, valid_out);
        end
        drive(1'b0, 4'b1111, 1'b1, 32'd5, 32'd3, 5'd15, 1'b1);
        step();
        checks++;
        if (illegal_operation !== 1'b0 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_end got ill=%b valid=%b exp 0 0",
                     illegal_operation, valid_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_back_to_back();
        test_overflow();
        test_slt();
        test_logic();
        test_stall_flush();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
